// File: rtl/rtc_time_set_ctrl_pkg.sv
// Shared definitions for the RTC time-set controller: FSM encoding and BCD field limits.
package rtc_time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam int HR_MAX_T  = 2;
    localparam int HR_MAX_U  = 3;
    localparam int MIN_MAX_T = 5;
    localparam int MIN_MAX_U = 9;

    localparam int TO_CNT_W  = 8;

endpackage

// File: rtl/rtc_time_set_ctrl_bcd2_inc.sv
// Combinational two-digit BCD incrementer that wraps to 00 after MAX_T:MAX_U.
module bcd2_inc #(
    parameter int TENS_W = 2,
    parameter int MAX_T  = 2,
    parameter int MAX_U  = 3
) (
    input  logic [TENS_W-1:0] tens_in,
    input  logic [3:0]        units_in,
    output logic [TENS_W-1:0] tens_out,
    output logic [3:0]        units_out
);

    localparam logic [TENS_W-1:0] MAX_T_V = TENS_W'(MAX_T);
    localparam logic [3:0]        MAX_U_V = 4'(MAX_U);
    localparam logic [TENS_W-1:0] ONE_T   = TENS_W'(1);

    // The field maximum is checked first so 23 -> 00 beats the units carry.
    always_comb begin
        tens_out  = tens_in;
        units_out = units_in + 4'd1;
        if (tens_in == MAX_T_V && units_in == MAX_U_V) begin
            tens_out  = '0;
            units_out = '0;
        end else if (units_in == 4'd9) begin
            tens_out  = tens_in + ONE_T;
            units_out = '0;
        end
    end

endmodule

// File: rtl/rtc_time_set_ctrl.sv
// Button-driven hours/minutes editor for the RTC: captures current time, edits it,
// issues a one-cycle load, blinks the active field and abandons idle edits.
module rtc_time_set_ctrl
    import rtc_time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [1:0] cur_hr_t,
    input  logic [3:0] cur_hr_u,
    input  logic [2:0] cur_min_t,
    input  logic [3:0] cur_min_u,
    output logic [1:0] set_hr_t,
    output logic [3:0] set_hr_u,
    output logic [2:0] set_min_t,
    output logic [3:0] set_min_u,
    output logic       load,
    output logic       editing,
    output logic       blank_hr,
    output logic       blank_min
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_TICKS - 1);

    state_t              state_q;
    state_t              state_nxt;
    logic [TO_CNT_W-1:0] to_cnt_q;
    logic                phase_q;
    logic                edit_active;
    logic                any_btn;
    logic                timeout_hit;

    logic [1:0] hr_t_inc;
    logic [3:0] hr_u_inc;
    logic [2:0] min_t_inc;
    logic [3:0] min_u_inc;

    bcd2_inc #(
        .TENS_W (2),
        .MAX_T  (HR_MAX_T),
        .MAX_U  (HR_MAX_U)
    ) u_hr_inc (
        .tens_in   (set_hr_t),
        .units_in  (set_hr_u),
        .tens_out  (hr_t_inc),
        .units_out (hr_u_inc)
    );

    bcd2_inc #(
        .TENS_W (3),
        .MAX_T  (MIN_MAX_T),
        .MAX_U  (MIN_MAX_U)
    ) u_min_inc (
        .tens_in   (set_min_t),
        .units_in  (set_min_u),
        .tens_out  (min_t_inc),
        .units_out (min_u_inc)
    );

    assign edit_active = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
    assign any_btn     = mode_btn || inc_btn;
    // A button on the expiring tick's edge keeps the edit alive.
    assign timeout_hit = edit_active && tick_1hz && !any_btn && (to_cnt_q == TO_LAST);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RUN: begin
                if (mode_btn) state_nxt = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (mode_btn)         state_nxt = ST_SET_MIN;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            ST_SET_MIN: begin
                if (mode_btn)         state_nxt = ST_COMMIT;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            ST_COMMIT: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            load    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            load    <= (state_nxt == ST_COMMIT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (any_btn || timeout_hit) begin
            to_cnt_q <= '0;
        end else if (tick_1hz && edit_active) begin
            to_cnt_q <= to_cnt_q + TO_CNT_W'(1);
        end
    end

    // Any button press restarts the blink with digits visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else if (any_btn || timeout_hit) begin
            phase_q <= 1'b0;
        end else if (tick_1hz && edit_active) begin
            phase_q <= ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_hr_t  <= '0;
            set_hr_u  <= '0;
            set_min_t <= '0;
            set_min_u <= '0;
        end else begin
            if (state_q == ST_RUN && mode_btn) begin
                set_hr_t  <= cur_hr_t;
                set_hr_u  <= cur_hr_u;
                set_min_t <= cur_min_t;
                set_min_u <= cur_min_u;
            end else if (state_q == ST_SET_HR && inc_btn && !mode_btn) begin
                set_hr_t  <= hr_t_inc;
                set_hr_u  <= hr_u_inc;
            end else if (state_q == ST_SET_MIN && inc_btn && !mode_btn) begin
                set_min_t <= min_t_inc;
                set_min_u <= min_u_inc;
            end
        end
    end

    assign editing   = edit_active;
    assign blank_hr  = (state_q == ST_SET_HR)  && phase_q;
    assign blank_min = (state_q == ST_SET_MIN) && phase_q;

endmodule
